// File: rtl/mprj_cp_pkg.sv
// Shared types and defaults for the checkpoint-sequence monitor.
package mprj_cp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PASS,
    ST_FAIL
  } cp_state_e;

  localparam int unsigned CP_W_DEF    = 16;
  localparam int unsigned DEPTH_DEF   = 8;
  localparam int unsigned TMO_W_DEF   = 24;
  localparam int unsigned STB_CYC_DEF = 4;

  // Table index width; a one-entry table still needs a one-bit index.
  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/cp_stable_filter.sv
// Synchronises an asynchronous bus and reports each value that stays put for
// STB_CYC consecutive samples, once per distinct value.
module cp_stable_filter #(
  parameter int unsigned CP_W    = 16,
  parameter int unsigned STB_CYC = 4
) (
  input  logic            mclk,
  input  logic            reset_n,
  input  logic            clr,
  input  logic [CP_W-1:0] cp_in,
  output logic            ev,
  output logic [CP_W-1:0] ev_val
);

  localparam int unsigned      CNT_W   = $clog2(STB_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STB_CYC);

  logic [CP_W-1:0]  sync1;
  logic [CP_W-1:0]  cp_sync;
  logic [CP_W-1:0]  cp_prev;
  logic [CP_W-1:0]  last_val;
  logic [CNT_W-1:0] run_cnt;
  logic             last_vld;

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= '0;
      cp_sync  <= '0;
      cp_prev  <= '0;
      run_cnt  <= '0;
      last_val <= '0;
      last_vld <= 1'b0;
    end else begin
      sync1   <= cp_in;
      cp_sync <= sync1;
      cp_prev <= cp_sync;
      // run_cnt = number of consecutive samples cp_prev has held, saturating
      if (cp_sync != cp_prev)
        run_cnt <= CNT_W'(1);
      else if (run_cnt != CNT_MAX)
        run_cnt <= run_cnt + CNT_W'(1);
      if (clr) begin
        last_vld <= 1'b0;
      end else if (ev) begin
        last_vld <= 1'b1;
        last_val <= cp_prev;
      end
    end
  end

  assign ev     = (run_cnt == CNT_MAX) && (!last_vld || (cp_prev != last_val));
  assign ev_val = cp_prev;

endmodule

// File: rtl/mprj_cp_monitor.sv
// Checkpoint-sequence monitor: matches stable checkpoint codes against a
// programmed ordered table and reports pass, fail or per-step watchdog timeout.
module mprj_cp_monitor
  import mprj_cp_pkg::*;
#(
  parameter int unsigned CP_W    = CP_W_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned TMO_W   = TMO_W_DEF,
  parameter int unsigned STB_CYC = STB_CYC_DEF,
  localparam int unsigned IDX_W  = idx_w(DEPTH)
) (
  input  logic             mclk,
  input  logic             reset_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [CP_W-1:0]  cfg_data,
  input  logic [IDX_W:0]   cfg_num,
  input  logic             cfg_strict,
  input  logic [TMO_W-1:0] cfg_tmo,
  input  logic             start,
  input  logic             abort,
  input  logic [CP_W-1:0]  cp_in,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [IDX_W:0]   step,
  output logic [CP_W-1:0]  fail_code
);

  localparam logic [IDX_W:0] NUM_MAX = (IDX_W + 1)'(DEPTH);

  cp_state_e        state;
  logic [CP_W-1:0]  tbl [DEPTH];
  logic [TMO_W-1:0] wdog;
  logic [TMO_W-1:0] wdog_dec;
  logic [IDX_W:0]   num_eff;
  logic [IDX_W:0]   step_inc;
  logic             arm;
  logic             hit;
  logic             ev;
  logic [CP_W-1:0]  ev_val;

  // Only a start that actually arms a run re-validates the filter history.
  assign arm      = start && !abort && (state != ST_RUN);
  assign num_eff  = (cfg_num > NUM_MAX) ? NUM_MAX : cfg_num;
  assign step_inc = step + (IDX_W + 1)'(1);
  assign hit      = ev && (ev_val == tbl[step[IDX_W-1:0]]);
  assign wdog_dec = (wdog == '0) ? '0 : wdog - TMO_W'(1);

  cp_stable_filter #(
    .CP_W    (CP_W),
    .STB_CYC (STB_CYC)
  ) u_filter (
    .mclk    (mclk),
    .reset_n (reset_n),
    .clr     (arm),
    .cp_in   (cp_in),
    .ev      (ev),
    .ev_val  (ev_val)
  );

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        tbl[i] <= '0;
    end else if (cfg_we && (state != ST_RUN)) begin
      tbl[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      step      <= '0;
      wdog      <= '0;
      timeout   <= 1'b0;
      fail_code <= '0;
    end else if (abort) begin
      state     <= ST_IDLE;
      step      <= '0;
      wdog      <= '0;
      timeout   <= 1'b0;
      fail_code <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (hit) begin
            step <= step_inc;
            wdog <= cfg_tmo;
            if (step_inc == num_eff)
              state <= ST_PASS;
          end else if (ev && cfg_strict) begin
            state     <= ST_FAIL;
            fail_code <= ev_val;
          end else if ((cfg_tmo != '0) && (wdog_dec == '0)) begin
            state   <= ST_FAIL;
            timeout <= 1'b1;
            wdog    <= '0;
          end else begin
            wdog <= wdog_dec;
          end
        end
        default: begin
          if (start) begin
            step      <= '0;
            wdog      <= cfg_tmo;
            timeout   <= 1'b0;
            fail_code <= '0;
            state     <= (num_eff == '0) ? ST_PASS : ST_RUN;
          end
        end
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign pass = (state == ST_PASS);
  assign fail = (state == ST_FAIL);

endmodule

// File: tb/tb_mprj_cp_monitor.sv
// Directed and randomized checks of mprj_cp_monitor against a segment-level
// reference model of the checkpoint sequence.
module tb_mprj_cp_monitor;

  localparam int unsigned CP_W    = 16;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TMO_W   = 24;
  localparam int unsigned STB_CYC = 4;
  localparam int unsigned IDX_W   = 3;

  logic             mclk       = 1'b0;
  logic             reset_n    = 1'b0;
  logic             cfg_we     = 1'b0;
  logic [IDX_W-1:0] cfg_addr   = '0;
  logic [CP_W-1:0]  cfg_data   = '0;
  logic [IDX_W:0]   cfg_num    = '0;
  logic             cfg_strict = 1'b0;
  logic [TMO_W-1:0] cfg_tmo    = '0;
  logic             start      = 1'b0;
  logic             abort      = 1'b0;
  logic [CP_W-1:0]  cp_in      = '0;
  logic             busy, pass, fail, timeout;
  logic [IDX_W:0]   step;
  logic [CP_W-1:0]  fail_code;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int          cyc;

  // reference model state for randomized runs
  logic [CP_W-1:0] tblm  [DEPTH];
  logic [CP_W-1:0] alpha [4];
  logic [CP_W-1:0] seg_v [16];
  int              seg_h [16];
  logic [CP_W-1:0] mv    [16];
  int              mh    [16];
  int              nseg, nm, n, ncfg, gp, mstep, mstate;
  logic [CP_W-1:0] mcode, lastv;
  logic            have_last, strict_r;

  always #5 mclk = ~mclk;

  mprj_cp_monitor #(
    .CP_W    (CP_W),
    .DEPTH   (DEPTH),
    .TMO_W   (TMO_W),
    .STB_CYC (STB_CYC)
  ) dut (
    .mclk       (mclk),
    .reset_n    (reset_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_num    (cfg_num),
    .cfg_strict (cfg_strict),
    .cfg_tmo    (cfg_tmo),
    .start      (start),
    .abort      (abort),
    .cp_in      (cp_in),
    .busy       (busy),
    .pass       (pass),
    .fail       (fail),
    .timeout    (timeout),
    .step       (step),
    .fail_code  (fail_code)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic write_tbl(input int idx, input logic [CP_W-1:0] val);
    cfg_we   = 1'b1;
    cfg_addr = IDX_W'(idx);
    cfg_data = val;
    tick();
    cfg_we   = 1'b0;
  endtask

  // new value on cp_in, start sampled on the third edge after the change
  task automatic arm(input logic [CP_W-1:0] pre);
    cp_in = pre;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_step(input logic [IDX_W:0] exp, input int budget, inout int c);
    while ((step !== exp) && (budget > 0)) begin
      tick();
      c++;
      budget--;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_fail"}, 32'(fail), 0);
    chk({tag, "_timeout"}, 32'(timeout), 0);
    chk({tag, "_step"}, 32'(step), 0);
    chk({tag, "_fail_code"}, 32'(fail_code), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no end of test, expected $finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    repeat (3) @(posedge mclk);
    #1;
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // basic pass with latency measurement
    write_tbl(0, 16'hAB60);
    write_tbl(1, 16'hAB6A);
    cfg_num = 4'd2; cfg_strict = 1'b1; cfg_tmo = 24'd1000;
    repeat (10) tick();
    arm(16'hAB60);
    cyc = 3;
    wait_step(4'd1, 30, cyc);
    chk("basic_lat1", 32'(cyc), STB_CYC + 3);
    chk("basic_busy1", 32'(busy), 1);
    while (cyc < 20) begin tick(); cyc++; end
    cp_in = 16'hAB6A;
    cyc = 0;
    wait_step(4'd2, 30, cyc);
    chk("basic_lat2", 32'(cyc), STB_CYC + 3);
    chk("basic_pass", 32'(pass), 1);
    chk("basic_busy", 32'(busy), 0);
    chk("basic_fail", 32'(fail), 0);

    // glitch of STB_CYC-1 cycles must not be reported
    arm(16'h1234);
    cp_in = 16'hAB60;
    repeat (15) tick();
    chk("glitch_fail", 32'(fail), 0);
    chk("glitch_step", 32'(step), 1);
    chk("glitch_busy", 32'(busy), 1);
    cp_in = 16'hAB6A;
    repeat (10) tick();
    chk("glitch_pass", 32'(pass), 1);

    // strict mismatch
    arm(16'h1234);
    cyc = 0;
    while ((fail !== 1'b1) && (cyc < 30)) begin tick(); cyc++; end
    chk("strict_fail", 32'(fail), 1);
    chk("strict_code", 32'(fail_code), 32'h1234);
    chk("strict_timeout", 32'(timeout), 0);
    chk("strict_step", 32'(step), 0);

    // lenient mismatch then full sequence
    cfg_strict = 1'b0;
    arm(16'h1234);
    repeat (15) tick();
    chk("lenient_busy", 32'(busy), 1);
    chk("lenient_fail", 32'(fail), 0);
    cp_in = 16'hAB60;
    repeat (10) tick();
    cp_in = 16'hAB6A;
    repeat (10) tick();
    chk("lenient_pass", 32'(pass), 1);
    chk("lenient_step", 32'(step), 2);

    // watchdog expiry
    cfg_tmo = 24'd100;
    arm(16'h1234);
    cyc = 0;
    while ((fail !== 1'b1) && (cyc < 200)) begin tick(); cyc++; end
    chk("wdog_window", 32'((cyc >= 99) && (cyc <= 101)), 1);
    chk("wdog_fail", 32'(fail), 1);
    chk("wdog_timeout", 32'(timeout), 1);

    // watchdog disabled
    cfg_tmo = '0;
    arm(16'h1234);
    repeat (10000) tick();
    chk("nowdog_busy", 32'(busy), 1);
    chk("nowdog_timeout", 32'(timeout), 0);

    // abort beats start, from RUN and from IDLE
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_run_busy", 32'(busy), 0);
    chk("abort_run_pass", 32'(pass), 0);
    chk("abort_run_fail", 32'(fail), 0);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_idle_busy", 32'(busy), 0);

    // table writes dropped during RUN; start ignored during RUN
    arm(16'h1234);
    write_tbl(0, 16'hBEEF);
    cp_in = 16'hAB60;
    repeat (12) tick();
    chk("we_run_step", 32'(step), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("start_in_run_step", 32'(step), 1);
    chk("start_in_run_busy", 32'(busy), 1);

    // asynchronous reset mid-run
    @(posedge mclk);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(posedge mclk);
    #1;
    reset_n = 1'b1;
    tick();

    // empty sequence
    cfg_num = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("num0_pass", 32'(pass), 1);
    chk("num0_busy", 32'(busy), 0);

    // randomized runs against the segment-level model
    cfg_tmo = '0;
    for (int r = 0; r < 30; r++) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      for (int k = 0; k < 4; k++) alpha[k] = CP_W'($urandom);
      n    = $urandom_range(1, DEPTH);
      ncfg = n;
      if ($urandom_range(0, 3) == 0) begin
        n    = DEPTH;
        ncfg = $urandom_range(DEPTH + 1, 2 * DEPTH - 1);
      end
      for (int i = 0; i < DEPTH; i++) begin
        tblm[i] = alpha[$urandom_range(0, 3)];
        write_tbl(i, tblm[i]);
      end
      strict_r   = 1'($urandom_range(0, 1));
      cfg_strict = strict_r;
      cfg_num    = (IDX_W + 1)'(ncfg);
      nseg = $urandom_range(4, 14);
      gp   = 0;
      for (int s = 0; s < nseg; s++) begin
        if (($urandom_range(0, 9) < 6) && (gp < n)) begin
          seg_v[s] = tblm[gp];
          gp++;
        end else begin
          seg_v[s] = alpha[$urandom_range(0, 3)];
        end
        seg_h[s] = $urandom_range(1, 7);
      end
      seg_h[nseg-1] = 20;

      arm(seg_v[0]);
      repeat (seg_h[0]) tick();
      for (int s = 1; s < nseg; s++) begin
        cp_in = seg_v[s];
        repeat (seg_h[s]) tick();
      end

      // model: merge equal neighbours; a value counts once it holds STB_CYC
      // samples and differs from the last counted value
      nm = 0;
      for (int s = 0; s < nseg; s++) begin
        if ((nm > 0) && (mv[nm-1] == seg_v[s])) begin
          mh[nm-1] += seg_h[s];
        end else begin
          mv[nm] = seg_v[s];
          mh[nm] = seg_h[s] + ((s == 0) ? 3 : 0);
          nm++;
        end
      end
      mstep = 0; mstate = 0; mcode = '0; have_last = 1'b0; lastv = '0;
      for (int m = 0; m < nm; m++) begin
        if ((mstate == 0) && (mh[m] >= int'(STB_CYC)) && (!have_last || (mv[m] != lastv))) begin
          have_last = 1'b1;
          lastv     = mv[m];
          if (mv[m] == tblm[mstep]) begin
            mstep++;
            if (mstep == n) mstate = 1;
          end else if (strict_r) begin
            mstate = 2;
            mcode  = mv[m];
          end
        end
      end
      chk($sformatf("rnd%0d_busy", r), 32'(busy), 32'(mstate == 0));
      chk($sformatf("rnd%0d_pass", r), 32'(pass), 32'(mstate == 1));
      chk($sformatf("rnd%0d_fail", r), 32'(fail), 32'(mstate == 2));
      chk($sformatf("rnd%0d_step", r), 32'(step), 32'(mstep));
      chk($sformatf("rnd%0d_code", r), 32'(fail_code), 32'(mcode));
      chk($sformatf("rnd%0d_timeout", r), 32'(timeout), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
